freq_sort: RTL

FREQ_SORT -- requirements
Module: freq_sort

---
 rtl/freq_sort_if.sv | 24 ++
 rtl/freq_sort.sv | 127 ++++++++++++
 2 files changed

// File: rtl/freq_sort_if.sv
// Handshake and data bundle between the symbol counter, the frequency sorter and the tree builder.
// master drives counts/start/ready; slave (the sorter) drives the sorted stream and status.
interface freq_sort_if;
  logic       Start;
  logic [8:0] Num0, Num1, Num2, Num3, Num4, Num5, Num6, Num7, Num8, Num9;
  logic       Out_ready;
  logic       Out_valid;
  logic [3:0] Out_sym;
  logic [8:0] Out_cnt;
  logic       Out_last;
  logic [3:0] Sym_total;
  logic       Busy;
  logic       Done;

  modport master (
    output Start, Num0, Num1, Num2, Num3, Num4, Num5, Num6, Num7, Num8, Num9, Out_ready,
    input  Out_valid, Out_sym, Out_cnt, Out_last, Sym_total, Busy, Done
  );

  modport slave (
    input  Start, Num0, Num1, Num2, Num3, Num4, Num5, Num6, Num7, Num8, Num9, Out_ready,
    output Out_valid, Out_sym, Out_cnt, Out_last, Sym_total, Busy, Done
  );
endinterface

// File: rtl/freq_sort.sv
// Sorts ten {count,symbol} entries ascending with an odd-even transposition network,
// then streams the nonzero-count entries out over a valid/ready handshake.
module freq_sort_cas #(
  parameter int KEY_W = 13
) (
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  output logic [KEY_W-1:0] lo,
  output logic [KEY_W-1:0] hi
);
  logic swap;
  assign swap = a > b;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

module freq_sort (
  input  logic     Clk_in,
  input  logic     nRst,
  freq_sort_if.slave bus
);
  localparam int NUM_SYM = 10;
  localparam int CNT_W   = 9;
  localparam int SYM_W   = 4;
  localparam int KEY_W   = CNT_W + SYM_W;

  typedef enum logic [1:0] {IDLE, SORT, EMIT, FIN} state_t;

  state_t state, state_nxt;

  // Key is {cnt, sym}, so a plain unsigned compare gives ties ordered by symbol.
  logic [NUM_SYM-1:0][KEY_W-1:0] ent, load_ent, ev_net, od_net;
  logic [3:0] phase, ptr, sym_total, nz_cnt;
  logic       out_valid, xfer, last_sort, at_last;
  logic [KEY_W-1:0] cur;

  assign load_ent[0] = {bus.Num0, 4'd0};
  assign load_ent[1] = {bus.Num1, 4'd1};
  assign load_ent[2] = {bus.Num2, 4'd2};
  assign load_ent[3] = {bus.Num3, 4'd3};
  assign load_ent[4] = {bus.Num4, 4'd4};
  assign load_ent[5] = {bus.Num5, 4'd5};
  assign load_ent[6] = {bus.Num6, 4'd6};
  assign load_ent[7] = {bus.Num7, 4'd7};
  assign load_ent[8] = {bus.Num8, 4'd8};
  assign load_ent[9] = {bus.Num9, 4'd9};

  always_comb begin
    nz_cnt = '0;
    for (int k = 0; k < NUM_SYM; k++)
      nz_cnt = nz_cnt + {3'b000, |load_ent[k][KEY_W-1:SYM_W]};
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SYM / 2; g++) begin : g_even
      freq_sort_cas #(.KEY_W(KEY_W)) u_cas (
        .a(ent[2*g]), .b(ent[2*g+1]), .lo(ev_net[2*g]), .hi(ev_net[2*g+1])
      );
    end
    for (g = 0; g < NUM_SYM / 2 - 1; g++) begin : g_odd
      freq_sort_cas #(.KEY_W(KEY_W)) u_cas (
        .a(ent[2*g+1]), .b(ent[2*g+2]), .lo(od_net[2*g+1]), .hi(od_net[2*g+2])
      );
    end
  endgenerate

  // End entries sit out the odd phases.
  assign od_net[0]         = ent[0];
  assign od_net[NUM_SYM-1] = ent[NUM_SYM-1];

  assign last_sort = (phase == 4'd9);
  assign at_last   = (ptr == 4'd9);
  assign out_valid = (state == EMIT);
  assign xfer      = out_valid && bus.Out_ready;

  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.Start) state_nxt = SORT;
      SORT: if (last_sort) state_nxt = (sym_total != 4'd0) ? EMIT : FIN;
      EMIT: if (xfer && at_last) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      ent       <= '0;
      phase     <= '0;
      ptr       <= '0;
      sym_total <= '0;
    end else begin
      case (state)
        IDLE: if (bus.Start) begin
          ent       <= load_ent;
          sym_total <= nz_cnt;
          phase     <= '0;
        end
        SORT: begin
          ent   <= phase[0] ? od_net : ev_net;
          phase <= phase + 4'd1;
          // Zero-count entries sort to the bottom; start reading past them.
          if (last_sort) ptr <= 4'd10 - sym_total;
        end
        EMIT: if (xfer && !at_last) ptr <= ptr + 4'd1;
        default: ;
      endcase
    end
  end

  assign cur = ent[ptr];

  assign bus.Out_valid = out_valid;
  assign bus.Out_sym   = out_valid ? cur[SYM_W-1:0] : '0;
  assign bus.Out_cnt   = out_valid ? cur[KEY_W-1:SYM_W] : '0;
  assign bus.Out_last  = out_valid && at_last;
  assign bus.Sym_total = sym_total;
  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = (state == FIN);
endmodule
